// File: rtl/pid_axis_seq_pkg.sv
// Shared types and defaults for the flight PID sequencer.
// Holds the sequencer state enum, default widths and calibration constants.
// Also provides a generic signed saturation helper used by the datapath.
package flght_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR  = 2'd1,
    S_TERM = 2'd2,
    S_DONE = 2'd3
  } seq_state_e;

  localparam int ANGLE_W           = 16;
  localparam int DEF_NUM_AXES      = 3;
  localparam int DEF_ERR_W         = 10;
  localparam int DEF_D_QUEUE_DEPTH = 14;
  localparam int DEF_D_SAT_W       = 6;
  localparam int DEF_D_COEFF       = 7;
  localparam int DEF_I_SHIFT       = 4;
  localparam int DEF_CORR_W        = 13;

  // Calibration flushes error history and integrators so post-cal samples
  // start from a clean state.
  localparam logic CAL_FLUSH_HIST = 1'b1;

  // Clamp a signed value to the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat_s(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      sat_s = hi;
    else if (v < lo) sat_s = lo;
    else             sat_s = v;
  endfunction

endpackage

// File: rtl/pid_axis_seq_if.sv
// Sample/correction bundle between the attitude source and the PID sequencer.
// master drives samples and mode controls, slave returns corrections.
// No flow control: vld is a strobe, overruns are flagged by the slave.
interface pid_axis_seq_if import flght_pkg::*; #(
  parameter int NUM_AXES = DEF_NUM_AXES,
  parameter int CORR_W   = DEF_CORR_W
);
  logic                                vld;
  logic                                inertial_cal;
  logic                                i_en;
  logic [NUM_AXES-1:0][ANGLE_W-1:0]    des;
  logic [NUM_AXES-1:0][ANGLE_W-1:0]    act;
  logic [NUM_AXES-1:0][CORR_W-1:0]     corr;
  logic                                corr_vld;
  logic                                busy;
  logic                                ovr_err;

  modport master (
    output vld, inertial_cal, i_en, des, act,
    input  corr, corr_vld, busy, ovr_err
  );

  modport slave (
    input  vld, inertial_cal, i_en, des, act,
    output corr, corr_vld, busy, ovr_err
  );
endinterface

// File: rtl/pid_axis_seq_d_queue.sv
// Per-axis error history delay line for the derivative term.
// Read is combinational from the oldest slot; shift lands on the next edge.
// No backpressure: shift_en is a one-cycle strobe, clr wins over shift.
module d_queue #(
  parameter int NUM_AXES = 3,
  parameter int DEPTH    = 14,
  parameter int W        = 10,
  parameter int AX_W     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            shift_en,
  input  logic [AX_W-1:0] ax,
  input  logic [W-1:0]    wr_dat,
  output logic [W-1:0]    rd_dat
);

  logic [W-1:0] hist_q [NUM_AXES][DEPTH];
  logic [W-1:0] hist_d [NUM_AXES][DEPTH];

  // Next history: flush everything, or push one sample into the selected axis.
  always_comb begin
    hist_d = hist_q;
    if (clr) begin
      for (int a = 0; a < NUM_AXES; a++)
        for (int i = 0; i < DEPTH; i++)
          hist_d[a][i] = '0;
    end else if (shift_en) begin
      for (int i = DEPTH - 1; i > 0; i--)
        hist_d[ax][i] = hist_q[ax][i-1];
      hist_d[ax][0] = wr_dat;
    end
  end

  // History registers with synchronous clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NUM_AXES; a++)
        for (int i = 0; i < DEPTH; i++)
          hist_q[a][i] <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rd_dat = hist_q[ax][DEPTH-1];

endmodule

// File: rtl/pid_axis_seq.sv
// Time-multiplexed P+I+D correction sequencer over NUM_AXES axes.
// Latency: corr_vld 2*NUM_AXES+1 edges after the edge that accepts vld.
// No backpressure: vld while busy is dropped and latched in sticky ovr_err.
module pid_axis_seq import flght_pkg::*; #(
  parameter int NUM_AXES      = DEF_NUM_AXES,
  parameter int ERR_W         = DEF_ERR_W,
  parameter int D_QUEUE_DEPTH = DEF_D_QUEUE_DEPTH,
  parameter int D_SAT_W       = DEF_D_SAT_W,
  parameter int D_COEFF       = DEF_D_COEFF,
  parameter int I_SHIFT       = DEF_I_SHIFT,
  parameter int CORR_W        = DEF_CORR_W
) (
  input  logic          clk,
  input  logic          rst,
  pid_axis_seq_if.slave bus
);

  localparam int AX_W  = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam int ACC_W = ERR_W + 4;
  localparam logic [AX_W-1:0] LAST_AX = AX_W'(NUM_AXES - 1);

  seq_state_e                          state_q, state_d;
  logic [AX_W-1:0]                     ax_q, ax_d;
  logic [NUM_AXES-1:0][ANGLE_W-1:0]    des_q, des_d, act_q, act_d;
  logic [ERR_W-1:0]                    err_q, err_d;
  logic [NUM_AXES-1:0][CORR_W-1:0]     shadow_q, shadow_d, corr_q, corr_d;
  logic [NUM_AXES-1:0][ACC_W-1:0]      acc_q, acc_d;
  logic                                corr_vld_q, corr_vld_d;
  logic                                ovr_err_q, ovr_err_d;

  logic [ERR_W-1:0]    hist_rd;
  logic                hist_shift;
  logic                cal_flush;
  logic signed [16:0]  raw_err;
  logic signed [31:0]  err_sat_s, err_s, p_s, diff_s, d_s, acc_s, i_s, sum_s;
  logic                unused_hi;

  assign cal_flush = bus.inertial_cal & CAL_FLUSH_HIST;

  d_queue #(
    .NUM_AXES (NUM_AXES),
    .DEPTH    (D_QUEUE_DEPTH),
    .W        (ERR_W),
    .AX_W     (AX_W)
  ) u_d_queue (
    .clk      (clk),
    .rst      (rst),
    .clr      (cal_flush),
    .shift_en (hist_shift),
    .ax       (ax_q),
    .wr_dat   (err_q),
    .rd_dat   (hist_rd)
  );

  // Shared datapath: error for the current axis, then P, D, I and their sum.
  always_comb begin
    raw_err   = $signed({act_q[ax_q][ANGLE_W-1], act_q[ax_q]})
              - $signed({des_q[ax_q][ANGLE_W-1], des_q[ax_q]});
    err_sat_s = sat_s(32'(raw_err), ERR_W);
    err_s     = 32'($signed(err_q));
    p_s       = (err_s >>> 1) + (err_s >>> 3);
    diff_s    = sat_s(err_s - 32'($signed(hist_rd)), D_SAT_W);
    d_s       = diff_s * D_COEFF;
    acc_s     = sat_s(32'($signed(acc_q[ax_q])) + err_s, ACC_W);
    i_s       = bus.i_en ? (acc_s >>> I_SHIFT) : 32'sd0;
    sum_s     = sat_s(p_s + d_s + i_s, CORR_W);
  end

  assign unused_hi = ^{err_sat_s[31:ERR_W], sum_s[31:CORR_W], acc_s[31:ACC_W]};

  // Sequencer next state: capture, per-axis ERR/TERM passes, then publish.
  always_comb begin
    state_d    = state_q;
    ax_d       = ax_q;
    des_d      = des_q;
    act_d      = act_q;
    err_d      = err_q;
    shadow_d   = shadow_q;
    corr_d     = corr_q;
    acc_d      = acc_q;
    corr_vld_d = 1'b0;
    hist_shift = 1'b0;
    ovr_err_d  = ovr_err_q | (bus.vld & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (bus.vld && !bus.inertial_cal) begin
          des_d   = bus.des;
          act_d   = bus.act;
          ax_d    = '0;
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        err_d   = err_sat_s[ERR_W-1:0];
        state_d = S_TERM;
      end
      S_TERM: begin
        shadow_d[ax_q] = sum_s[CORR_W-1:0];
        hist_shift     = 1'b1;
        if (bus.i_en) acc_d[ax_q] = acc_s[ACC_W-1:0];
        if (ax_q == LAST_AX) begin
          state_d = S_DONE;
        end else begin
          ax_d    = ax_q + AX_W'(1);
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        // All lanes publish together; calibration suppresses the update.
        if (!bus.inertial_cal) begin
          corr_d     = shadow_q;
          corr_vld_d = 1'b1;
        end
        ax_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.inertial_cal) corr_d = '0;
    if (cal_flush)        acc_d  = '0;
  end

  // All sequencer state and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ax_q       <= '0;
      des_q      <= '0;
      act_q      <= '0;
      err_q      <= '0;
      shadow_q   <= '0;
      corr_q     <= '0;
      acc_q      <= '0;
      corr_vld_q <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ax_q       <= ax_d;
      des_q      <= des_d;
      act_q      <= act_d;
      err_q      <= err_d;
      shadow_q   <= shadow_d;
      corr_q     <= corr_d;
      acc_q      <= acc_d;
      corr_vld_q <= corr_vld_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  assign bus.corr     = corr_q;
  assign bus.corr_vld = corr_vld_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.ovr_err  = ovr_err_q;

endmodule

// File: tb/tb_pid_axis_seq.sv
// Randomized and directed bench for pid_axis_seq against a sample-level model.
// The model keeps per-axis error history queues and integrators in plain ints.
// Checks latency, lane values, overrun, calibration and mid-sequence reset.
module tb_pid_axis_seq;

  localparam int NA = 3;
  localparam int CW = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pid_axis_seq_if #(.NUM_AXES(NA), .CORR_W(CW)) bus ();

  pid_axis_seq #(
    .NUM_AXES(NA), .ERR_W(10), .D_QUEUE_DEPTH(14), .D_SAT_W(6),
    .D_COEFF(7), .I_SHIFT(4), .CORR_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  int          m_hist [NA][$];
  int          m_acc  [NA];
  int          m_corr [NA];
  logic [15:0] des_v  [NA];
  logic [15:0] act_v  [NA];
  logic        ien_v;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic void model_reset();
    for (int a = 0; a < NA; a++) begin
      m_hist[a].delete();
      repeat (14) m_hist[a].push_back(0);
      m_acc[a]  = 0;
      m_corr[a] = 0;
    end
  endfunction

  function automatic void model_sample();
    int e, old, p, d, i;
    for (int a = 0; a < NA; a++) begin
      e   = clamp(int'($signed(act_v[a])) - int'($signed(des_v[a])), -512, 511);
      old = m_hist[a].pop_front();
      m_hist[a].push_back(e);
      p   = (e >>> 1) + (e >>> 3);
      d   = clamp(e - old, -32, 31) * 7;
      i   = 0;
      if (ien_v) begin
        m_acc[a] = clamp(m_acc[a] + e, -8192, 8191);
        i        = m_acc[a] >>> 4;
      end
      m_corr[a] = clamp(p + d + i, -4096, 4095);
    end
  endfunction

  function automatic int lane(input int a);
    return int'($signed(bus.corr[a]));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic clear_vecs();
    for (int a = 0; a < NA; a++) begin
      des_v[a] = '0;
      act_v[a] = '0;
    end
  endtask

  // One accepted sample: checks busy, latency, pulse width and every lane.
  task automatic run_sample();
    int  n;
    bit  seen;
    @(negedge clk);
    for (int a = 0; a < NA; a++) begin
      bus.des[a] = des_v[a];
      bus.act[a] = act_v[a];
    end
    bus.i_en = ien_v;
    bus.vld  = 1'b1;
    @(posedge clk); #1;
    check("busy_after_vld", int'(bus.busy), 1);
    @(negedge clk);
    bus.vld = 1'b0;
    seen = 1'b0;
    n    = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.corr_vld) begin
        seen = 1'b1;
        n    = k;
      end
    end
    model_sample();
    if (!seen) begin
      check("corr_vld_timeout", 0, 1);
    end else begin
      check("corr_vld_latency", n, 2 * NA + 1);
      for (int a = 0; a < NA; a++) check($sformatf("corr_lane%0d", a), lane(a), m_corr[a]);
      @(posedge clk); #1;
      check("corr_vld_width", int'(bus.corr_vld), 0);
      check("busy_back_idle", int'(bus.busy), 0);
    end
  endtask

  function automatic logic [15:0] rand_angle();
    int mode;
    mode = $urandom_range(0, 2);
    if (mode == 0) return 16'($urandom_range(0, 600) - 300);
    if (mode == 1) return 16'($urandom);
    return 16'($urandom_range(0, 40) - 20);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int pulses;
    int corr_nz;
    rst              = 1'b1;
    bus.vld          = 1'b0;
    bus.inertial_cal = 1'b0;
    bus.i_en         = 1'b0;
    bus.des          = '0;
    bus.act          = '0;
    ien_v            = 1'b0;
    clear_vecs();
    model_reset();

    // Reset state
    do_reset();
    for (int a = 0; a < NA; a++) check($sformatf("rst_corr%0d", a), lane(a), 0);
    check("rst_corr_vld", int'(bus.corr_vld), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ovr_err", int'(bus.ovr_err), 0);

    // Single positive error on axis 0
    clear_vecs();
    act_v[0] = 16'h0100;
    ien_v    = 1'b1;
    run_sample();
    check("pos_err_corr0", lane(0), 393);
    check("pos_err_corr1", lane(1), 0);
    check("pos_err_corr2", lane(2), 0);

    // Single negative error on axis 0
    do_reset();
    clear_vecs();
    des_v[0] = 16'h0100;
    run_sample();
    check("neg_err_corr0", lane(0), -400);

    // Saturated error, integrator windup to its clamp
    do_reset();
    clear_vecs();
    act_v[0] = 16'h7FFF;
    des_v[0] = 16'h8000;
    for (int k = 1; k <= 20; k++) begin
      run_sample();
      if (k == 1)  check("sat_first_corr0", lane(0), 566);
      if (k == 20) check("sat_last_corr0", lane(0), 829);
    end

    // Randomized samples with random integrator enable and idle gaps
    do_reset();
    for (int s = 0; s < 40; s++) begin
      for (int a = 0; a < NA; a++) begin
        des_v[a] = rand_angle();
        act_v[a] = rand_angle();
      end
      ien_v = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_sample();
    end

    // Back-to-back vld: second is dropped and flagged
    do_reset();
    check("ovr_clear_before", int'(bus.ovr_err), 0);
    for (int a = 0; a < NA; a++) begin
      des_v[a] = rand_angle();
      act_v[a] = rand_angle();
    end
    ien_v = 1'b1;
    @(negedge clk);
    for (int a = 0; a < NA; a++) begin
      bus.des[a] = des_v[a];
      bus.act[a] = act_v[a];
    end
    bus.i_en = ien_v;
    bus.vld  = 1'b1;
    @(negedge clk);
    for (int a = 0; a < NA; a++) bus.act[a] = act_v[a] + 16'd77;
    @(negedge clk);
    bus.vld = 1'b0;
    model_sample();
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.corr_vld) begin
        pulses++;
        for (int a = 0; a < NA; a++) check($sformatf("ovr_corr%0d", a), lane(a), m_corr[a]);
      end
    end
    check("ovr_pulse_count", pulses, 1);
    check("ovr_err_set", int'(bus.ovr_err), 1);
    clear_vecs();
    act_v[1] = 16'h0040;
    run_sample();
    check("ovr_err_sticky", int'(bus.ovr_err), 1);

    // Calibration: no updates, corr forced to zero, history flushed
    @(negedge clk);
    bus.inertial_cal = 1'b1;
    pulses  = 0;
    corr_nz = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      bus.vld = (k % 3 == 0);
      @(posedge clk); #1;
      if (bus.corr_vld) pulses++;
      if (k > 0) for (int a = 0; a < NA; a++) if (lane(a) != 0) corr_nz++;
    end
    @(negedge clk);
    bus.vld = 1'b0;
    check("cal_no_pulse", pulses, 0);
    check("cal_corr_zero", corr_nz, 0);
    check("cal_not_busy", int'(bus.busy), 0);
    bus.inertial_cal = 1'b0;
    model_reset();
    clear_vecs();
    act_v[0] = 16'h0100;
    ien_v    = 1'b1;
    run_sample();
    check("post_cal_corr0", lane(0), 393);

    // Reset during a TERM pass
    @(negedge clk);
    for (int a = 0; a < NA; a++) bus.act[a] = 16'h0020;
    bus.vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.vld = 1'b0;
    @(posedge clk); #1;
    check("term_busy", int'(bus.busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_term_busy", int'(bus.busy), 0);
    check("rst_term_corr0", lane(0), 0);
    check("rst_term_corr_vld", int'(bus.corr_vld), 0);
    check("rst_term_ovr", int'(bus.ovr_err), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.corr_vld) pulses++;
    end
    check("rst_term_no_pulse", pulses, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
